// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmitter
//
// Purpose : FSM state encoding, baud counter width and the baud-select to
//           clocks-per-bit mapping used by uart_tx and uart_baud_gen.
// Ports   : none (package).
// Config  : UART_TX_PARITY_EN (consumed in uart_tx; the PARITY encoding is
//           always present so both builds share one state type).

package uart_pkg;

    // Wide enough for the slowest rate: CPB = 16 << 7 = 2048, counts 0..2047.
    localparam int BAUD_CNT_W = 11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3,
        ST_PARITY = 3'd4
    } uart_state_e;

    // Clocks per bit for a baud select code: 16 << br.
    function automatic logic [BAUD_CNT_W:0] cpb_from_br(input logic [2:0] br);
        logic [BAUD_CNT_W:0] cpb;
        cpb = 12'd16 << br;
        return cpb;
    endfunction

    // Terminal count of the baud counter (CPB-1). Computed one bit wider so
    // that br=7 (2048) does not wrap to zero before the subtraction.
    function automatic logic [BAUD_CNT_W-1:0] cpb_last(input logic [2:0] br);
        logic [BAUD_CNT_W:0] last;
        last = cpb_from_br(br) - 12'd1;
        return last[BAUD_CNT_W-1:0];
    endfunction

endpackage : uart_pkg

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter producing a one-cycle bit tick
//
// Purpose : counts 0..CPB-1 and wraps; bit_tick_o marks the last cycle of
//           every bit period. clear_i holds the count at zero so that the
//           first bit of a frame starts a full period from the start edge.
// Ports   : clk_i       system clock, rising edge
//           rst_i       asynchronous active-high reset
//           clear_i     synchronous clear (count forced to 0)
//           br_i [2:0]  baud select, CPB = 16 << br_i
//           bit_tick_o  high while count == CPB-1

module uart_baud_gen
    import uart_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clear_i,
    input  logic [2:0] br_i,
    output logic       bit_tick_o
);

    logic [BAUD_CNT_W-1:0] count_q;
    logic [BAUD_CNT_W-1:0] count_d;
    logic [BAUD_CNT_W-1:0] count_last;

    assign count_last = cpb_last(br_i);
    assign bit_tick_o = !clear_i && (count_q == count_last);

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (count_q == count_last) begin
            count_d = '0;
        end else begin
            count_d = count_q + 11'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule : uart_baud_gen

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - parameterised UART transmitter, 8N1 by default, LSB first
//
// Purpose : latches DBUS on a start request and shifts out start bit, data
//           bits (LSB first), optional even parity, and stop bit on txd.
//           txd_doneH pulses for the final cycle of the stop bit.
// Ports   : sysclk      system clock, rising edge
//           rst_n       asynchronous reset, ACTIVE-HIGH despite the name
//           DBUS        parallel data, sampled only when a frame starts
//           txd_startH  level-sensitive start request, ignored while busy
//           txd         serial output, idle/mark = 1
//           txd_doneH   one-cycle pulse at end of stop bit
// Params  : data_bits (5..9), transmitted_bit_counter_bits, br (CPB=16<<br)
// Config  : UART_TX_PARITY_EN inserts an even-parity bit before the stop bit.

module uart_tx
    import uart_pkg::*;
#(
    parameter int         data_bits                    = 8,
    parameter int         transmitted_bit_counter_bits = 4,
    parameter logic [2:0] br                           = 3'b000
) (
    input  logic                 sysclk,
    input  logic                 rst_n,
    input  logic [data_bits-1:0] DBUS,
    input  logic                 txd_startH,
    output logic                 txd,
    output logic                 txd_doneH
);

    localparam int CNT_W = transmitted_bit_counter_bits;

    // Bit counter value while the last data bit is on the line: the start
    // bit is counted as bit 0, so data bit i is on the line at count i+1.
    localparam logic [CNT_W-1:0] LAST_DATA_CNT = CNT_W'(data_bits);

    uart_state_e            state_q,  state_d;
    logic [data_bits-1:0]   shift_q,  shift_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic                   parity_q, parity_d;
    logic                   txd_q,    txd_d;

    logic                   baud_clear;
    logic                   bit_tick;

    uart_baud_gen u_baud_gen (
        .clk_i      (sysclk),
        .rst_i      (rst_n),
        .clear_i    (baud_clear),
        .br_i       (br),
        .bit_tick_o (bit_tick)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        parity_d   = parity_q;
        baud_clear = 1'b0;
        txd_doneH  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Counter held at zero so START gets a full CPB from the
                // edge that samples the request.
                baud_clear = 1'b1;
                bit_cnt_d  = '0;
                if (txd_startH) begin
                    shift_d  = DBUS;
                    parity_d = ^DBUS;
                    state_d  = ST_START;
                end
            end

            ST_START: begin
                if (bit_tick) begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    state_d   = ST_DATA;
                end
            end

            ST_DATA: begin
                if (bit_tick) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == LAST_DATA_CNT) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end

            ST_PARITY: begin
                if (bit_tick) begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    state_d   = ST_STOP;
                end
            end

            ST_STOP: begin
                if (bit_tick) begin
                    txd_doneH = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // txd is registered from the next state so the line is glitch-free
        // and changes on the same edge as the state.
        case (state_d)
            ST_START:  txd_d = 1'b0;
            ST_DATA:   txd_d = shift_d[0];
            ST_PARITY: txd_d = parity_d;
            default:   txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge sysclk or posedge rst_n) begin
        if (rst_n) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            parity_q  <= 1'b0;
            txd_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            parity_q  <= parity_d;
            txd_q     <= txd_d;
        end
    end

    assign txd = txd_q;

endmodule : uart_tx

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx (br=000 and br=011 instances)

module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] dbus0, dbus3;
    logic       start0, start3;
    logic       txd0, done0, txd3, done3;

    int n_assert = 0;
    int n_fail   = 0;

    // Expected {txd, txd_doneH} per clock cycle.
    logic [1:0] exp_q[$];

    always #5 clk = ~clk;

    uart_tx #(.data_bits(8), .transmitted_bit_counter_bits(4), .br(3'b000)) dut0 (
        .sysclk(clk), .rst_n(rst), .DBUS(dbus0), .txd_startH(start0),
        .txd(txd0), .txd_doneH(done0)
    );

    uart_tx #(.data_bits(8), .transmitted_bit_counter_bits(4), .br(3'b011)) dut3 (
        .sysclk(clk), .rst_n(rst), .DBUS(dbus3), .txd_startH(start3),
        .txd(txd3), .txd_doneH(done3)
    );

    function automatic logic [1:0] obs(input int sel);
        return (sel == 0) ? {txd0, done0} : {txd3, done3};
    endfunction

    task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
        n_assert++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed txd,done=%b expected=%b", tag, got, exp);
        end
    endtask

    // Queue one frame's expected line waveform: start, 8 data LSB first,
    // optional even parity, stop; done high only on the frame's last cycle.
    task automatic push_frame(input logic [7:0] d, input int cpb);
        logic bits[$];
        int   total;
        int   k;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
        bits.push_back(^d);
`endif
        bits.push_back(1'b1);
        total = bits.size() * cpb;
        k = 0;
        foreach (bits[b]) begin
            for (int c = 0; c < cpb; c++) begin
                k++;
                exp_q.push_back({bits[b], (k == total) ? 1'b1 : 1'b0});
            end
        end
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(2'b10);
    endtask

    // Compare up to max_n queued cycles on the selected DUT, one per negedge.
    // With poke set, DBUS/start of dut0 are disturbed during the DATA phase.
    task automatic drain(input int sel, input string tag, input int max_n, input bit poke);
        int i;
        i = 0;
        while (exp_q.size() > 0 && i < max_n) begin
            if (poke) begin
                if (i == 40)  begin dbus0 = 8'h00; start0 = 1'b1; end
                if (i == 70)  start0 = 1'b0;
                if (i == 90)  start0 = 1'b1;
                if (i == 120) start0 = 1'b0;
            end
            chk(tag, obs(sel), exp_q.pop_front());
            i++;
            @(negedge clk);
        end
    endtask

    initial begin
        rst    = 1'b1;
        dbus0  = 8'h00;
        dbus3  = 8'h00;
        start0 = 1'b0;
        start3 = 1'b0;

        // Reset held for 5 cycles: line idle, no done.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("reset_dut0", obs(0), 2'b10);
            chk("reset_dut3", obs(1), 2'b10);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", obs(0), 2'b10);

        // Single frame 8'h85 at br=000, one-cycle start pulse.
        dbus0 = 8'h85; start0 = 1'b1;
        push_frame(8'h85, 16);
        push_idle(3);
        @(negedge clk);
        start0 = 1'b0;
        drain(0, "single_85", 100000, 1'b0);

        // Held start: back-to-back frames separated by exactly one idle cycle.
        dbus0 = 8'h85; start0 = 1'b1;
        push_frame(8'h85, 16);
        push_idle(1);
        push_frame(8'h85, 16);
        push_idle(1);
        push_frame(8'h85, 16);
        @(negedge clk);
        drain(0, "held_start", 100000, 1'b0);
        start0 = 1'b0;
        push_idle(4);
        drain(0, "held_release", 100000, 1'b0);

        // Baud select 011: 128 cycles per bit, all-ones data.
        dbus3 = 8'hFF; start3 = 1'b1;
        push_frame(8'hFF, 128);
        push_idle(2);
        @(negedge clk);
        start3 = 1'b0;
        drain(1, "br011_ff", 100000, 1'b0);

        // Busy protection: DBUS and start disturbed mid-frame are ignored.
        dbus0 = 8'h85; start0 = 1'b1;
        push_frame(8'h85, 16);
        push_idle(20);
        @(negedge clk);
        start0 = 1'b0;
        drain(0, "busy_protect", 100000, 1'b1);

        // Reset mid-DATA: line returns to 1 without a clock edge.
        dbus0 = 8'h85; start0 = 1'b1;
        push_frame(8'h85, 16);
        @(negedge clk);
        start0 = 1'b0;
        drain(0, "pre_abort", 40, 1'b0);
        exp_q.delete();
        #2 rst = 1'b1;
        #1 chk("async_abort", obs(0), 2'b10);
        @(negedge clk);
        chk("abort_hold", obs(0), 2'b10);
        rst = 1'b0;
        push_idle(40);
        @(negedge clk);
        drain(0, "after_abort_idle", 100000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_uart_tx

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Parameterised asynchronous-serial (UART) transmitter: 8N1 framing by default, LSB first.
- Parallel word on DBUS is latched on a start request and shifted out on txd as start bit, data bits, then stop bit.
- txd_doneH pulses at frame end.
- Sits between a host/controller and the serial line, on a single system clock.

Parameters:
- data_bits, 8, number of data bits per frame (5..9 supported).
- transmitted_bit_counter_bits, 4, width of the frame bit counter; must hold data_bits+2 (data_bits+3 with parity).
- br, 3'b000, baud select; clocks per bit CPB = 16 << br (000=16, 001=32, … 111=2048).

Ports:
- sysclk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  reset; asynchronous, active-high (1 = reset) despite the legacy name.
- DBUS  input  data_bits  parallel data to transmit; sampled only at frame start.
- txd_startH  input  1  active-high start request; level-sensitive.
- txd  output  1  serial line; idle/mark = 1.
- txd_doneH  output  1  one-cycle active-high pulse at end of stop bit.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, txd=1, txd_doneH=0.
  - Bit counter, baud counter and shift register cleared.
  - Reset mid-frame aborts immediately; txd returns to 1 without waiting for a clock.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - txd=1.
  - If txd_startH=1 at a rising edge: latch DBUS into the shift register, clear the baud counter, go to START.
  - txd=0 from that edge, giving one cycle of latency from the sampled request.
- START: txd=0 for CPB cycles, then DATA.
- DATA:
  - txd = shift_reg[0] for CPB cycles per bit, then shift right.
  - data_bits bits, LSB first, then STOP.
- STOP:
  - txd=1 for CPB cycles.
  - txd_doneH=1 during the final cycle of STOP only.
  - Next state IDLE.
- Baud counter:
  - Counts 0..CPB-1 and wraps.
  - Bit boundary when count==CPB-1.
  - Counter width = clog2(2048)=11 bits.
- Bit counter:
  - Counts transmitted bits 0..data_bits+1 and clears in IDLE.
  - Width set by transmitted_bit_counter_bits.
- Frame length: exactly (data_bits+2)*CPB cycles from the first txd=0 cycle to the last stop cycle.
- Start request while busy (START/DATA/STOP): ignored.
- DBUS changes mid-frame: ignored (latched copy is used).
- txd_startH held high continuously:
  - After txd_doneH, IDLE samples start on the next edge.
  - Back-to-back frames result, with exactly one idle (txd=1) cycle between stop bit and next start bit.
- txd_startH deasserted before frame end: no effect on the current frame.
- txd_doneH is never asserted outside STOP, nor during reset.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP.
  - It transmits even parity (XOR of the latched data bits) for CPB cycles.
  - Frame becomes (data_bits+3)*CPB cycles.
- Undefined: no parity state; frame as above.

Decomposition:
- Package uart_pkg:
  - state enum (IDLE, START, DATA, STOP, PARITY).
  - Function/constant mapping br to CPB.
  - Baud counter width constant (11).
- One natural sub-module: uart_baud_gen.
  - Holds the baud counter.
  - Inputs clk/reset/clear/br.
  - Outputs a one-cycle bit_tick at count==CPB-1.

Test Plan:
- Reset: hold rst_n=1 for 5 cycles -> txd=1, txd_doneH=0. Assert reset mid-DATA -> txd=1 asynchronously and state IDLE.
- Single frame, br=000, DBUS=8'h85, pulse txd_startH one cycle:
  - Start bit 0 for 16 cycles.
  - Data LSB first 1,0,1,0,0,0,0,1, 16 cycles each.
  - Stop 1 for 16 cycles.
  - txd_doneH=1 exactly on cycle 160 of the frame.
- Held start, br=000, txd_startH=1 constantly, DBUS=8'h85 -> repeated 160-cycle frames, each followed by one idle cycle and one txd_doneH pulse per frame.
- Baud select, br=3'b011, DBUS=8'hFF -> each bit 128 cycles; frame 1280 cycles; data bits all 1.
- Busy protection: toggle txd_startH and change DBUS to 8'h00 during DATA -> current frame bits unchanged, no extra frame started until after txd_doneH.
- With UART_TX_PARITY_EN, DBUS=8'h85 (three 1s) -> parity bit 1 inserted before stop; frame 176 cycles at br=000.
